cve2_fetch_req_ctrl: RTL
========================

// Module: cve2_fetch_req_ctrl
// PURPOSE
// Instruction-bus request side of the fetch path: issues word-aligned fetch requests on the
// instruction memory interface (req/gnt/rvalid), tracks up to NUM_REQS outstanding requests and
// pushes valid responses into cve2_fetch_fifo. Handles branches by clearing the FIFO,
// redirecting the fetch address and discarding responses to pre-branch requests.
// PARAMETERS
// NUM_REQS  2  max outstanding bus requests; must equal the NUM_REQS of cve2_fetch_fifo
// PORTS
// clk_i           in   1         clock
// rst_ni          in   1         reset, asynchronous, active-low
// req_i           in   1         fetch enable from core; 0 = issue no new requests
// branch_i        in   1         redirect fetch to addr_i (single-cycle pulse)
// addr_i          in   32        branch target (halfword aligned)
// busy_o          out  1         request held or any response outstanding
// fifo_busy_i     in   NUM_REQS  fill status of upper FIFO entries
// fifo_clear_o    out  1         FIFO clear
// fifo_valid_o    out  1         push response into FIFO
// fifo_addr_o     out  32        address for FIFO on clear
// fifo_rdata_o    out  32        response data to FIFO
// fifo_err_o      out  1         response bus error to FIFO
// instr_req_o     out  1         bus request
// instr_gnt_i     in   1         bus grant
// instr_addr_o    out  32        bus word address, [1:0] always 2'b00
// instr_rvalid_i  in   1         bus response valid (in order, >=1 cycle after gnt)
// instr_rdata_i   in   32        bus response data
// instr_err_i     in   1         bus response error
// BEHAVIOUR
// - Reset: instr_req_o=0, instr_addr_o=0, fifo_valid_o=0, fifo_clear_o=0, busy_o=0; all
//   outstanding/discard bits 0, fetch_addr_q=0, FSM=IDLE.
// - fifo_clear_o=branch_i, fifo_addr_o=addr_i (combinational).
// - Outstanding tracking: rdata_outstanding_q[NUM_REQS-1:0] thermometer shift register;
//   bit set on gnt, lowest bit cleared on rvalid. discard_q[NUM_REQS-1:0] parallel to it.
// - Slot free: ~&rdata_outstanding_q AND FIFO room: ~&(fifo_busy_i | outstanding reversed);
//   on branch_i the FIFO term is ignored (FIFO is cleared that cycle).
// - FSM IDLE: instr_req_o = req_i & slot_free. instr_addr_o = branch_i ? {addr_i[31:2],2'b00}
//   : fetch_addr_q. If req asserted and ~gnt -> WAIT_GNT, latch addr into stored_addr_q.
// - FSM WAIT_GNT: instr_req_o=1 regardless of req_i/slot_free, instr_addr_o=stored_addr_q
//   (stable until gnt, per protocol). On gnt -> IDLE.
// - Branch in WAIT_GNT: set branch_pend_q, latch target; held request continues; when
//   granted it is marked discard. Next request (IDLE) uses branch target; clears branch_pend_q.
// - On gnt: fetch_addr_q <= granted addr + 4 (32-bit wrap, 0xFFFFFFFC -> 0x0).
// - On branch_i: set discard bit for every outstanding entry; request granted same cycle
//   with old address (WAIT_GNT) also discarded; request granted same cycle with new target
//   is kept.
// - fifo_valid_o = instr_rvalid_i & ~discard_q[0] & ~branch_i; rdata/err pass through
//   combinationally (zero latency). Discarded responses only retire outstanding slot.
// - Simultaneous gnt+rvalid: shift out retiring slot and set new slot same cycle; count
//   unchanged.
// - rvalid with no outstanding: protocol error; ignored (assertion).
// - req_i=0: no new requests; held request in WAIT_GNT still completes; responses accepted.
// - busy_o = instr_req_o | (|rdata_outstanding_q).
// - Reset mid-transaction: all state cleared asynchronously; bus side must also reset.
// TESTING
// 1. branch_i=1, addr_i=0x100, req_i=1, gnt same cycle -> instr_addr_o=0x100, then 0x104,
//    0x108 (gnt each cycle); third request blocked until first rvalid (NUM_REQS=2).
// 2. addr_i=0x102 branch -> instr_addr_o=0x100, fifo_addr_o=0x102, fifo_clear_o=1 one cycle.
// 3. Two outstanding (0x200,0x204), branch to 0x300 -> both rvalids give fifo_valid_o=0,
//    next request 0x300, its response pushed with fifo_valid_o=1.
// 4. Hold gnt=0 for 3 cycles at 0x40, branch to 0x80 in cycle 2 -> instr_addr_o stays 0x40
//    until gnt; 0x40 response discarded; next request 0x80.
// 5. fifo_busy_i=2'b11 with 0 outstanding -> instr_req_o=0; busy drops -> request resumes.
// 6. rvalid with instr_err_i=1 -> fifo_err_o=1, fifo_valid_o=1; fetch at 0xFFFFFFFC wraps to 0x0.

Source files
------------

// File: rtl/cve2_fetch_req_ctrl.sv
// Fetch request side: issues word-aligned instruction bus requests, tracks outstanding
// responses and forwards the ones that are still wanted into the fetch FIFO.
module cve2_fetch_req_ctrl #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         addr_i,
    output logic                busy_o,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i
);

    typedef enum logic {IDLE, WAIT_GNT} state_e;

    state_e              state_q, state_d;
    logic [31:0]         fetch_addr_q, fetch_addr_d;
    logic [31:0]         stored_addr_q, stored_addr_d;
    logic                branch_pend_q, branch_pend_d;
    logic [NUM_REQS-1:0] rdata_outstanding_q, rdata_outstanding_d, rdata_outstanding_s;
    logic [NUM_REQS-1:0] discard_q, discard_d, discard_s;
    logic [NUM_REQS-1:0] outstanding_rev;
    logic [NUM_REQS:0]   below_ext;
    logic [31:0]         branch_addr;
    logic                fifo_room, slot_free, rvalid_ok, gnt_valid, new_discard, new_here;

    assign branch_addr  = {addr_i[31:2], 2'b00};
    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = addr_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;

    // Outstanding requests reserve FIFO entries from the top down
    always_comb begin
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            outstanding_rev[i] = rdata_outstanding_q[int'(NUM_REQS) - 1 - i];
        end
    end

    assign fifo_room    = ~&(fifo_busy_i | outstanding_rev);
    assign slot_free    = ~&rdata_outstanding_q & (branch_i | fifo_room);
    assign rvalid_ok    = instr_rvalid_i & rdata_outstanding_q[0];
    assign fifo_valid_o = rvalid_ok & ~discard_q[0] & ~branch_i;
    assign busy_o       = instr_req_o | (|rdata_outstanding_q);
    assign gnt_valid    = instr_req_o & instr_gnt_i;

    // Request FSM: a request not granted is held with a stable address until granted
    always_comb begin
        state_d       = state_q;
        stored_addr_d = stored_addr_q;
        fetch_addr_d  = fetch_addr_q;
        branch_pend_d = branch_pend_q;
        instr_req_o   = 1'b0;
        instr_addr_o  = fetch_addr_q;
        new_discard   = 1'b0;
        case (state_q)
            IDLE: begin
                instr_req_o  = req_i & slot_free;
                instr_addr_o = branch_i ? branch_addr : fetch_addr_q;
                if (instr_req_o && instr_gnt_i) begin
                    fetch_addr_d = instr_addr_o + 32'd4;
                end else begin
                    if (branch_i) fetch_addr_d = branch_addr;
                    if (instr_req_o) begin
                        state_d       = WAIT_GNT;
                        stored_addr_d = instr_addr_o;
                    end
                end
            end
            WAIT_GNT: begin
                instr_req_o  = 1'b1;
                instr_addr_o = stored_addr_q;
                if (branch_i) fetch_addr_d = branch_addr;
                if (instr_gnt_i) begin
                    state_d       = IDLE;
                    branch_pend_d = 1'b0;
                    new_discard   = branch_pend_q | branch_i;
                    if (!(branch_pend_q || branch_i)) fetch_addr_d = stored_addr_q + 32'd4;
                end else if (branch_i) begin
                    branch_pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Retire the oldest slot on rvalid, append the granted request above the survivors
    always_comb begin
        rdata_outstanding_s = rvalid_ok ? (rdata_outstanding_q >> 1) : rdata_outstanding_q;
        discard_s           = rvalid_ok ? (discard_q >> 1) : discard_q;
        below_ext           = {rdata_outstanding_s, 1'b1};
        rdata_outstanding_d = rdata_outstanding_s;
        discard_d           = '0;
        new_here            = 1'b0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            new_here = gnt_valid & ~rdata_outstanding_s[i] & below_ext[i];
            rdata_outstanding_d[i] = rdata_outstanding_s[i] | new_here;
            discard_d[i] = (rdata_outstanding_s[i] & (discard_s[i] | branch_i))
                         | (new_here & new_discard);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q             <= IDLE;
            fetch_addr_q        <= '0;
            stored_addr_q       <= '0;
            branch_pend_q       <= 1'b0;
            rdata_outstanding_q <= '0;
            discard_q           <= '0;
        end else begin
            state_q             <= state_d;
            fetch_addr_q        <= fetch_addr_d;
            stored_addr_q       <= stored_addr_d;
            branch_pend_q       <= branch_pend_d;
            rdata_outstanding_q <= rdata_outstanding_d;
            discard_q           <= discard_d;
        end
    end

    // A response with nothing outstanding is a bus protocol violation
    rvalid_has_slot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_rvalid_i |-> rdata_outstanding_q[0]);

endmodule
